servo_pwm_array: RTL and testbench
==================================

SERVO_PWM_ARRAY -- requirements
Module: servo_pwm_array

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter N_CH, default 4: number of servo channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 21: width of the period counter and of every pulse-width value.
REQ-003 The block SHALL have parameter PERIOD, default 500000: frame length in clk cycles (~20 ms).
REQ-004 The block SHALL have parameter MIN_PW, default 16000: lowest legal pulse width in cycles.
REQ-005 The block SHALL have parameter MAX_PW, default 66000: highest legal pulse width in cycles.
REQ-006 The block SHALL have parameter STEP_DIV, default 2500: clk cycles between sweep steps.
REQ-007 The block SHALL have parameter STEP, default 1: pulse-width increment per sweep step.

Ports (name, direction, width, meaning):
REQ-008 The block SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-009 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-010 The block SHALL have port mode, input, 2*N_CH: per-channel mode (00 hold, 01 sweep, 10 centre, 11 off).
REQ-011 The block SHALL have port pos_valid, input, 1: position-load request.
REQ-012 The block SHALL have port pos_ch, input, 3: target channel of the load.
REQ-013 The block SHALL have port pos_data, input, CNT_W: requested pulse width.
REQ-014 The block SHALL have port pos_ready, output, 1: load accepted when pos_valid and pos_ready are both high.
REQ-015 The block SHALL have port servo, output, N_CH: PWM outputs.
REQ-016 The block SHALL have port frame_start, output, 1: one-cycle pulse when the period counter equals 0.
REQ-017 The block SHALL have port sweep_dir, output, N_CH: current sweep direction per channel (1 = increasing).

Function
REQ-018 The period counter SHALL count 0..PERIOD-1 and then wrap to 0.
REQ-019 Each channel SHALL hold a working value wv[ch] and an active value pw[ch].
REQ-020 servo[ch] SHALL be registered and high exactly when counter < pw[ch] and mode[ch] != 11; mode 11 SHALL force a low output.
REQ-021 pw[ch] SHALL load from wv[ch] only on the cycle the counter wraps PERIOD-1 -> 0, so no pulse is ever truncated or extended mid-frame.
REQ-022 A load SHALL be accepted when pos_valid, pos_ready and pos_ch < N_CH are all true.
REQ-023 An accepted load SHALL write clamp(pos_data, MIN_PW, MAX_PW) into wv[pos_ch].
REQ-024 A load with pos_ch >= N_CH SHALL be dropped silently while still completing the handshake.
REQ-025 pos_ready SHALL be low only when the counter equals PERIOD-1, the shadow-transfer cycle, and high otherwise.
REQ-026 In mode 00, wv SHALL change only through loads.
REQ-027 In mode 10, wv SHALL be forced each cycle to CENTER = (MIN_PW+MAX_PW)/2, and loads to that channel SHALL be ignored.
REQ-028 In mode 01, a shared step divider counting 0..STEP_DIV-1 SHALL produce a tick on STEP_DIV-1; on each tick wv SHALL move STEP toward the current direction.
REQ-029 A sweep step that would cross MAX_PW (dir up) or MIN_PW (dir down) SHALL saturate wv at the limit and toggle dir on that same tick; the next tick SHALL move in the new direction.
REQ-030 All pulse-width arithmetic SHALL be done at CNT_W+1 bits so that no overflow or underflow wraps.
REQ-031 If a load and a sweep tick hit the same channel in the same cycle, the load SHALL win and the direction SHALL be unchanged.
REQ-032 A mode change SHALL take effect on wv the next cycle, and on servo at the next frame boundary.
REQ-033 sweep_dir SHALL be held, not updated, outside mode 01.

Reset
REQ-034 While rst_n is low, the block SHALL hold counter = 0 and step divider = 0.
REQ-035 While rst_n is low, wv and pw for every channel SHALL equal CENTER.
REQ-036 While rst_n is low, sweep_dir SHALL be all ones, servo all zeros, frame_start 0 and pos_ready 0.
REQ-037 Reset asserted mid-frame SHALL drive servo low immediately (asynchronously).
REQ-038 After rst_n deasserts, the first frame_start SHALL occur on the first clk edge and pos_ready SHALL go high on the same edge.

Verification
REQ-039 Reset then all channels in mode 00: servo high for exactly 41000 cycles of each 500000-cycle frame, and frame_start has a period of 500000.
REQ-040 Loading ch2 with 10000 mid-frame: the current frame keeps width 41000, the next frame has width 16000 (clamped), and other channels are unchanged.
REQ-041 Channel 0 in mode 01 with STEP_DIV=4 and wv=65999: after one tick wv=66000, after the next tick wv=66000 saturated with sweep_dir[0]=0, and the next tick gives 65999.
REQ-042 Holding pos_valid when the counter is at PERIOD-1: pos_ready is 0 and the load is accepted one cycle later.
REQ-043 A load to ch1 coinciding with a sweep tick on ch1: wv[1] equals the clamped load value and the direction is unchanged.
REQ-044 rst_n pulsed low mid-pulse: servo drops low without waiting for clk, and all registers return to their reset values.

Source files
------------

// File: rtl/servo_pwm_array.sv
// servo_pwm_array: multi-channel servo PWM generator with per-channel hold/sweep/centre/off modes.
// Working values are written by loads or the sweep; active widths are taken from them only at frame wrap.
module servo_pwm_array #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 21,
  parameter int PERIOD   = 500000,
  parameter int MIN_PW   = 16000,
  parameter int MAX_PW   = 66000,
  parameter int STEP_DIV = 2500,
  parameter int STEP     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*N_CH-1:0]   mode,
  input  logic                pos_valid,
  input  logic [2:0]          pos_ch,
  input  logic [CNT_W-1:0]    pos_data,
  output logic                pos_ready,
  output logic [N_CH-1:0]     servo,
  output logic                frame_start,
  output logic [N_CH-1:0]     sweep_dir
);
  localparam int DIV_W = $clog2(STEP_DIV + 1);
  localparam logic [CNT_W:0] L_MIN  = (CNT_W+1)'(MIN_PW);
  localparam logic [CNT_W:0] L_MAX  = (CNT_W+1)'(MAX_PW);
  localparam logic [CNT_W:0] L_STEP = (CNT_W+1)'(STEP);
  localparam logic [CNT_W-1:0] L_CTR  = CNT_W'((MIN_PW + MAX_PW) / 2);
  localparam logic [CNT_W-1:0] L_MINW = CNT_W'(MIN_PW);
  localparam logic [CNT_W-1:0] L_MAXW = CNT_W'(MAX_PW);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(PERIOD - 1);
  localparam logic [DIV_W-1:0] L_DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] r_div;
  logic             r_fs;
  logic             r_ready;
  logic             w_wrap;
  logic             w_tick;
  logic             w_acc;
  logic [CNT_W-1:0] w_clamp;

  assign w_wrap      = r_cnt == L_LAST;
  assign w_cnt_nxt   = w_wrap ? '0 : r_cnt + 1'b1;
  assign w_tick      = r_div == L_DIV_LAST;
  assign w_acc       = pos_valid && r_ready && ({1'b0, pos_ch} < 4'(N_CH));
  assign w_clamp     = (pos_data < L_MINW) ? L_MINW : (pos_data > L_MAXW) ? L_MAXW : pos_data;
  assign pos_ready   = r_ready;
  assign frame_start = r_fs;

  // Ready is registered from the next count so it is low exactly while the counter sits at PERIOD-1.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_div   <= '0;
      r_fs    <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      r_fs    <= r_cnt == '0;
      r_ready <= w_cnt_nxt != L_LAST;
    end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [1:0]       w_m;
    logic [CNT_W:0]   w_wv;
    logic [CNT_W:0]   w_up;
    logic [CNT_W-1:0] w_dn;
    logic [CNT_W-1:0] w_swp;
    logic             w_hit;
    logic             w_flip;
    logic             w_step;
    logic [CNT_W-1:0] r_wv;
    logic [CNT_W-1:0] r_pw;
    logic             r_dir;
    logic             r_off;
    logic             r_servo;
    assign w_m    = mode[2*c +: 2];
    assign w_wv   = {1'b0, r_wv};
    assign w_up   = w_wv + L_STEP;
    assign w_dn   = CNT_W'(w_wv - L_STEP);
    assign w_flip = r_dir ? (w_up > L_MAX) : (w_wv < L_MIN + L_STEP);
    assign w_swp  = r_dir ? (w_flip ? L_MAXW : w_up[CNT_W-1:0]) : (w_flip ? L_MINW : w_dn);
    assign w_hit  = w_acc && (pos_ch == 3'(c)) && (w_m != 2'b10);
    assign w_step = !w_hit && (w_m == 2'b01) && w_tick;
    assign servo[c]     = r_servo;
    assign sweep_dir[c] = r_dir;
    // The off state is latched with the width so a mode change only reaches the pin at a frame boundary.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_wv    <= L_CTR;
        r_pw    <= L_CTR;
        r_dir   <= 1'b1;
        r_off   <= 1'b0;
        r_servo <= 1'b0;
      end else begin
        r_wv    <= w_hit ? w_clamp : (w_m == 2'b10) ? L_CTR : w_step ? w_swp : r_wv;
        r_dir   <= (w_step && w_flip) ? ~r_dir : r_dir;
        r_pw    <= w_wrap ? r_wv : r_pw;
        r_off   <= w_wrap ? (w_m == 2'b11) : r_off;
        r_servo <= !r_off && (r_cnt < r_pw);
      end
  end
endmodule

// File: tb/tb_servo_pwm_array.sv
// tb_servo_pwm_array: directed checks of servo_pwm_array with a 200-cycle frame, limits 40..120, centre 80.
module tb_servo_pwm_array;
  localparam int P = 200;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  mode = '0;
  logic        pos_valid = 1'b0;
  logic [2:0]  pos_ch = '0;
  logic [20:0] pos_data = '0;
  logic        pos_ready;
  logic        frame_start;
  logic [3:0]  servo;
  logic [3:0]  sweep_dir;
  int n_vec = 0;
  int n_err = 0;
  int w[4];

  always #5 clk = ~clk;

  servo_pwm_array #(
    .N_CH(4), .CNT_W(21), .PERIOD(P), .MIN_PW(40), .MAX_PW(120), .STEP_DIV(4), .STEP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .pos_valid(pos_valid), .pos_ch(pos_ch),
    .pos_data(pos_data), .pos_ready(pos_ready), .servo(servo), .frame_start(frame_start),
    .sweep_dir(sweep_dir)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int d);
    pos_valid = 1'b1;
    pos_ch    = 3'(ch);
    pos_data  = 21'(d);
    step(1);
    pos_valid = 1'b0;
  endtask

  function automatic logic [31:0] wv(input int c);
    return c == 0 ? 32'(dut.g_ch[0].r_wv) : c == 1 ? 32'(dut.g_ch[1].r_wv) :
           c == 2 ? 32'(dut.g_ch[2].r_wv) : 32'(dut.g_ch[3].r_wv);
  endfunction

  // Waits for frame_start, then counts high cycles per channel over one frame; optional load at cycle ld_at.
  task automatic measure(input int ld_at, input int ld_ch, input int ld_d);
    int k = 0;
    w = '{default: 0};
    while (!frame_start && k < P + 2) begin
      step(1);
      k++;
    end
    chk("fs_found", 32'(frame_start), 1);
    for (int i = 0; i < P; i++) begin
      if (i == ld_at) begin
        pos_valid = 1'b1;
        pos_ch    = 3'(ld_ch);
        pos_data  = 21'(ld_d);
      end
      if (i == ld_at + 1) pos_valid = 1'b0;
      for (int c = 0; c < 4; c++) if (servo[c]) w[c]++;
      step(1);
    end
  endtask

  initial begin
    int k;
    step(3);
    chk("rst_servo", 32'(servo), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_ready", 32'(pos_ready), 0);
    chk("rst_dir", 32'(sweep_dir), 4'hF);
    chk("rst_wv0", wv(0), 80);
    #2 rst_n = 1'b1;
    step(1);
    chk("first_fs", 32'(frame_start), 1);
    chk("first_ready", 32'(pos_ready), 1);

    measure(-10, 0, 0);
    for (int c = 0; c < 4; c++) chk("w_hold", w[c], 80);
    chk("fs_period", 32'(frame_start), 1);

    measure(50, 2, 10);
    chk("w2_cur_frame", w[2], 80);
    chk("wv2_clamp_lo", wv(2), 40);
    measure(-10, 0, 0);
    chk("w2_next_frame", w[2], 40);
    chk("w0_unchanged", w[0], 80);
    chk("w1_unchanged", w[1], 80);
    chk("w3_unchanged", w[3], 80);

    step(P - 3);
    chk("ready_198", 32'(pos_ready), 1);
    step(1);
    chk("ready_last", 32'(pos_ready), 0);
    pos_valid = 1'b1;
    pos_ch    = 3'd1;
    pos_data  = 21'd100;
    step(1);
    chk("ready_wrap", 32'(pos_ready), 1);
    chk("wv1_not_yet", wv(1), 80);
    step(1);
    pos_valid = 1'b0;
    chk("wv1_late_load", wv(1), 100);

    load(5, 60);
    chk("drop_wv1", wv(1), 100);
    chk("drop_wv3", wv(3), 80);
    load(3, 500);
    chk("wv3_clamp_hi", wv(3), 120);

    mode = 8'b11_10_00_00;
    step(1);
    load(2, 60);
    chk("wv2_centre", wv(2), 80);
    measure(-10, 0, 0);
    chk("w0_mode", w[0], 80);
    chk("w1_mode", w[1], 100);
    chk("w2_centre", w[2], 80);
    chk("w3_off", w[3], 0);

    load(0, 119);
    mode[1:0] = 2'b01;
    k = 0;
    while (wv(0) == 119 && k < 10) begin
      step(1);
      k++;
    end
    chk("sw_reach_max", wv(0), 120);
    chk("sw_dir_up", 32'(sweep_dir[0]), 1);
    step(4);
    chk("sw_sat_max", wv(0), 120);
    chk("sw_dir_down", 32'(sweep_dir[0]), 0);
    step(4);
    chk("sw_back", wv(0), 119);

    mode[3:2] = 2'b01;
    step(3);
    pos_valid = 1'b1;
    pos_ch    = 3'd1;
    pos_data  = 21'd30;
    step(1);
    pos_valid = 1'b0;
    chk("coll_wv1", wv(1), 40);
    chk("coll_dir1", 32'(sweep_dir[1]), 1);
    chk("coll_wv0", wv(0), 118);
    step(4);
    chk("coll_next_wv1", wv(1), 41);
    chk("coll_next_wv0", wv(0), 117);

    load(0, 40);
    chk("sw_ld_min", wv(0), 40);
    step(3);
    chk("sw_sat_min", wv(0), 40);
    chk("sw_dir_up2", 32'(sweep_dir[0]), 1);
    step(4);
    chk("sw_up_again", wv(0), 41);
    mode[1:0] = 2'b00;
    step(8);
    chk("hold_wv0", wv(0), 41);
    chk("hold_dir0", 32'(sweep_dir[0]), 1);

    chk("pre_rst_servo0", 32'(servo[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_servo", 32'(servo), 0);
    chk("async_dir", 32'(sweep_dir), 4'hF);
    chk("async_fs", 32'(frame_start), 0);
    chk("async_ready", 32'(pos_ready), 0);
    chk("async_cnt", 32'(dut.r_cnt), 0);
    chk("async_wv0", wv(0), 80);
    chk("async_wv1", wv(1), 80);
    mode = '0;
    step(2);
    #2 rst_n = 1'b1;
    step(1);
    chk("re_fs", 32'(frame_start), 1);
    chk("re_ready", 32'(pos_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
